// File: rtl/obi_lockstep_stagger.sv
// Staggered N-core lockstep adapter: core 0 drives the OBI bus, follower k runs k*NCYCLES behind and is checked against the leader.
// Latency: leader path combinational; follower k responses delayed exactly k*NCYCLES cycles; mismatch_o registered 1 cycle after detection.
// Backpressure: none added; bus_gnt_i is the leader's grant and is replayed to followers through the delay lines.
module obi_lockstep_stagger #(
  parameter int NCORES  = 3,
  parameter int NCYCLES = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic [NCORES-1:0]            core_req_i,
  input  logic [NCORES-1:0]            core_we_i,
  input  logic [NCORES*(DATA_W/8)-1:0] core_be_i,
  input  logic [NCORES*ADDR_W-1:0]     core_addr_i,
  input  logic [NCORES*DATA_W-1:0]     core_wdata_i,
  output logic [NCORES-1:0]            core_gnt_o,
  output logic [NCORES-1:0]            core_rvalid_o,
  output logic [NCORES*DATA_W-1:0]     core_rdata_o,
  output logic                         bus_req_o,
  output logic                         bus_we_o,
  output logic [DATA_W/8-1:0]          bus_be_o,
  output logic [ADDR_W-1:0]            bus_addr_o,
  output logic [DATA_W-1:0]            bus_wdata_o,
  input  logic                         bus_gnt_i,
  input  logic                         bus_rvalid_i,
  input  logic [DATA_W-1:0]            bus_rdata_i,
  output logic [NCORES-1:0]            release_o,
  output logic [NCORES-1:0]            mismatch_o,
  output logic                         err_o,
  output logic                         locked_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = (NCORES - 1) * NCYCLES;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  typedef struct packed {
    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  typedef enum logic [1:0] {ST_OFF, ST_FILL, ST_LOCKED} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  req_t            r_ref_line [DEPTH];
  rsp_t            r_rsp_line [DEPTH];
  req_t            w_lead_req;
  rsp_t            w_bus_rsp;
  logic            w_line_run;
  logic [NCORES-1:0] w_release;
  logic [NCORES-1:0] w_cmp_mis;
  logic [NCORES-1:0] r_mismatch;
  logic            r_err;

  // Leader request and bus response as tuples; the bus is a straight passthrough of core 0
  assign w_lead_req = {core_req_i[0], core_we_i[0], core_be_i[BE_W-1:0],
                       core_addr_i[ADDR_W-1:0], core_wdata_i[DATA_W-1:0]};
  assign w_bus_rsp  = {bus_gnt_i, bus_rvalid_i, bus_rdata_i};

  assign bus_req_o   = w_lead_req.req;
  assign bus_we_o    = w_lead_req.we;
  assign bus_be_o    = w_lead_req.be;
  assign bus_addr_o  = w_lead_req.addr;
  assign bus_wdata_o = w_lead_req.wdata;

  assign core_gnt_o[0]             = bus_gnt_i;
  assign core_rvalid_o[0]          = bus_rvalid_i;
  assign core_rdata_o[DATA_W-1:0]  = bus_rdata_i;

  // Lines only advance while lockstep is running; anything else discards in-flight history
  assign w_line_run = enable_i && (r_state != ST_OFF);

  // State and fill counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: OFF -> FILL on enable, FILL counts up to the full stagger depth, then LOCKED
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_OFF: begin
        w_cnt_nxt = '0;
        if (enable_i) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (r_cnt == CNT_MAX) w_state_nxt = ST_LOCKED;
        else                  w_cnt_nxt   = r_cnt + 1'b1;
      end
      ST_LOCKED: begin
        w_cnt_nxt = CNT_MAX;
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_cnt_nxt   = '0;
      end
    endcase
    if (!enable_i) begin
      w_state_nxt = ST_OFF;
      w_cnt_nxt   = '0;
    end
  end

  // Reference and response delay lines, cleared whenever lockstep is not running
  always_ff @(posedge clk_i) begin
    if (rst_i || !w_line_run) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ref_line[i] <= '0;
        r_rsp_line[i] <= '0;
      end
    end else begin
      r_ref_line[0] <= w_lead_req;
      r_rsp_line[0] <= w_bus_rsp;
      for (int i = 1; i < DEPTH; i++) begin
        r_ref_line[i] <= r_ref_line[i-1];
        r_rsp_line[i] <= r_rsp_line[i-1];
      end
    end
  end

  assign w_release[0] = (r_state != ST_OFF);
  assign w_cmp_mis[0] = 1'b0;

  for (genvar k = 1; k < NCORES; k++) begin : g_fol
    localparam logic [CW-1:0] TAP = CW'(k * NCYCLES);
    req_t              w_fol;
    req_t              w_ref;
    rsp_t              w_rsp;
    logic [DATA_W-1:0] w_lane_mask;

    assign w_fol = {core_req_i[k], core_we_i[k], core_be_i[k*BE_W +: BE_W],
                    core_addr_i[k*ADDR_W +: ADDR_W], core_wdata_i[k*DATA_W +: DATA_W]};
    assign w_ref = r_ref_line[k*NCYCLES-1];
    assign w_rsp = r_rsp_line[k*NCYCLES-1];

    for (genvar b = 0; b < BE_W; b++) begin : g_lane
      assign w_lane_mask[b*8 +: 8] = {8{w_ref.be[b]}};
    end

    assign w_release[k] = (r_state != ST_OFF) && (r_cnt >= TAP);

    // Only write data in enabled byte lanes takes part in the comparison
    assign w_cmp_mis[k] = w_release[k] &&
                          ((w_fol.req != w_ref.req) ||
                           (w_ref.req && ((w_fol.we != w_ref.we) ||
                                          (w_fol.be != w_ref.be) ||
                                          (w_fol.addr != w_ref.addr) ||
                                          (w_ref.we && (|((w_fol.wdata ^ w_ref.wdata) & w_lane_mask))))));

    assign core_gnt_o[k]                   = w_rsp.gnt;
    assign core_rvalid_o[k]                = w_rsp.rvalid;
    assign core_rdata_o[k*DATA_W +: DATA_W] = w_rsp.rdata;
  end

  // Mismatch pulse and sticky error; a new mismatch beats a simultaneous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mismatch <= '0;
      r_err      <= 1'b0;
    end else begin
      r_mismatch <= enable_i ? w_cmp_mis : '0;
      if (enable_i && (|w_cmp_mis)) r_err <= 1'b1;
      else if (clear_i)             r_err <= 1'b0;
    end
  end

  assign release_o  = w_release;
  assign mismatch_o = r_mismatch;
  assign err_o      = r_err;
  assign locked_o   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_obi_lockstep_stagger.sv
// Bench for obi_lockstep_stagger (3 cores, stagger 2): directed vectors with literal checks
// plus a time-indexed history model compared against every output on every cycle.
module tb_obi_lockstep_stagger;

  localparam int NC  = 3;
  localparam int NCY = 2;
  localparam int DEP = (NC - 1) * NCY;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tb_req_t;

  logic          clk = 1'b0;
  logic          rst_i, enable_i, clear_i;
  logic [2:0]    core_req_i, core_we_i;
  logic [11:0]   core_be_i;
  logic [95:0]   core_addr_i, core_wdata_i;
  logic [2:0]    core_gnt_o, core_rvalid_o;
  logic [95:0]   core_rdata_o;
  logic          bus_req_o, bus_we_o;
  logic [3:0]    bus_be_o;
  logic [31:0]   bus_addr_o, bus_wdata_o;
  logic          bus_gnt_i, bus_rvalid_i;
  logic [31:0]   bus_rdata_i;
  logic [2:0]    release_o, mismatch_o;
  logic          err_o, locked_o;

  int n_chk  = 0;
  int n_fail = 0;

  obi_lockstep_stagger #(.NCORES(NC), .NCYCLES(NCY), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .release_o(release_o), .mismatch_o(mismatch_o), .err_o(err_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per-cycle history of what the leader asked and what the bus answered; the model
  // derives every output from the cycle index relative to the first FILL cycle.
  tb_req_t     h_lead [1024];
  logic        h_gnt  [1024];
  logic        h_rv   [1024];
  logic [31:0] h_rd   [1024];
  int          m_cyc   = 0;
  logic        m_valid = 1'b0;
  logic        m_on    = 1'b0;
  int          m_start = 0;
  logic        m_err   = 1'b0;
  logic [2:0]  m_mis   = 3'b000;

  function automatic logic differs(input tb_req_t f, input tb_req_t l);
    logic d;
    d = (f.req != l.req);
    if (l.req && f.req) begin
      if (f.we != l.we || f.be != l.be || f.addr != l.addr) d = 1'b1;
      if (l.we)
        for (int b = 0; b < 4; b++)
          if (l.be[b] && (f.wdata[b*8 +: 8] != l.wdata[b*8 +: 8])) d = 1'b1;
    end
    return d;
  endfunction

  task automatic mchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model %s cycle %0d: got %0h expected %0h", nm, m_cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : model
    logic [2:0] e_rel, e_gnt, e_rv, det;
    logic [31:0] e_rd;
    tb_req_t f;
    int idx;
    h_lead[m_cyc] = {core_req_i[0], core_we_i[0], core_be_i[3:0], core_addr_i[31:0], core_wdata_i[31:0]};
    h_gnt[m_cyc]  = bus_gnt_i;
    h_rv[m_cyc]   = bus_rvalid_i;
    h_rd[m_cyc]   = bus_rdata_i;
    e_rel = 3'b000;
    for (int k = 0; k < NC; k++)
      e_rel[k] = m_on && ((m_cyc - m_start) >= k * NCY);
    if (m_valid) begin
      mchk("release", release_o, e_rel);
      mchk("locked", locked_o, m_on && ((m_cyc - m_start) >= DEP + 1));
      mchk("mismatch", mismatch_o, m_mis);
      mchk("err", err_o, m_err);
      mchk("bus_req", {bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o}, h_lead[m_cyc]);
      e_gnt = 3'b000;
      e_rv  = 3'b000;
      for (int k = 0; k < NC; k++) begin
        idx  = m_cyc - k * NCY;
        e_rd = 32'h0;
        if (m_on && idx >= m_start) begin
          e_gnt[k] = h_gnt[idx];
          e_rv[k]  = h_rv[idx];
          e_rd     = h_rd[idx];
        end
        if (k == 0) begin
          e_gnt[0] = bus_gnt_i;
          e_rv[0]  = bus_rvalid_i;
          e_rd     = bus_rdata_i;
        end
        mchk($sformatf("rdata%0d", k), core_rdata_o[k*32 +: 32], e_rd);
      end
      mchk("gnt", core_gnt_o, e_gnt);
      mchk("rvalid", core_rvalid_o, e_rv);
    end
    // model update for the coming edge
    if (rst_i) begin
      m_valid = 1'b1;
      m_on    = 1'b0;
      m_err   = 1'b0;
      m_mis   = 3'b000;
    end else if (m_valid) begin
      det = 3'b000;
      for (int k = 1; k < NC; k++) begin
        f = {core_req_i[k], core_we_i[k], core_be_i[k*4 +: 4], core_addr_i[k*32 +: 32], core_wdata_i[k*32 +: 32]};
        if (enable_i && e_rel[k] && differs(f, h_lead[m_cyc - k * NCY])) det[k] = 1'b1;
      end
      m_mis = det;
      if (det != 3'b000) m_err = 1'b1;
      else if (clear_i)  m_err = 1'b0;
      if (!enable_i) m_on = 1'b0;
      else if (!m_on) begin
        m_on    = 1'b1;
        m_start = m_cyc + 1;
      end
    end
    m_cyc++;
  end

  // ---------------- stimulus ----------------
  // Followers replay the leader's own request stream k*NCY cycles later.
  tb_req_t drv_hist [1024];
  int      sc   = 0;
  logic    g_en = 1'b0;
  tb_req_t idle_r = '0;

  function automatic tb_req_t mk(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    tb_req_t r;
    r.req = 1'b1; r.we = we; r.be = be; r.addr = a; r.wdata = d;
    return r;
  endfunction

  task automatic step(input tb_req_t lead, input logic g, input logic rv, input logic [31:0] rd, input logic clr);
    tb_req_t r;
    @(posedge clk); #1;
    enable_i = g_en;
    clear_i  = clr;
    drv_hist[sc] = lead;
    for (int k = 0; k < NC; k++) begin
      if (k == 0) r = lead;
      else if (sc >= k * NCY) r = drv_hist[sc - k * NCY];
      else r = '0;
      core_req_i[k]            = r.req;
      core_we_i[k]             = r.we;
      core_be_i[k*4 +: 4]      = r.be;
      core_addr_i[k*32 +: 32]  = r.addr;
      core_wdata_i[k*32 +: 32] = r.wdata;
    end
    bus_gnt_i = g; bus_rvalid_i = rv; bus_rdata_i = rd;
    sc++;
    #1;
  endtask

  task automatic tick();
    step(idle_r, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  logic [2:0] rel_tab  [7];
  logic       lock_tab [7];

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0;
    core_req_i = '0; core_we_i = '0; core_be_i = '0; core_addr_i = '0; core_wdata_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    rel_tab  = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b011, 3'b111, 3'b111};
    lock_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    repeat (3) tick();
    rst_i = 1'b0;

    // reset state
    tick();
    chk("reset release", release_o, 3'b000);
    chk("reset locked", locked_o, 1'b0);
    chk("reset err", err_o, 1'b0);
    chk("reset mismatch", mismatch_o, 3'b000);
    chk("reset follower rvalid", core_rvalid_o[2:1], 2'b00);

    // start-up release sequence: cycle 0 carries enable, edge 0 samples it
    g_en = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      tick();
      chk($sformatf("startup release c%0d", c), release_o, rel_tab[c]);
      chk($sformatf("startup locked c%0d", c), locked_o, lock_tab[c]);
    end

    // locked read of 0x100, response DEADBEEF at T
    step(mk(1'b0, 4'hF, 32'h100, 32'h0), 1'b1, 1'b0, 32'h0, 1'b0);
    step(idle_r, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("read rvalid T", core_rvalid_o, 3'b001);
    chk("read rdata0 T", core_rdata_o[31:0], 32'hDEADBEEF);
    for (int d = 1; d <= 5; d++) begin
      tick();
      chk($sformatf("read rvalid T+%0d", d), core_rvalid_o, (d == 2) ? 3'b010 : (d == 4) ? 3'b100 : 3'b000);
      if (d == 2) chk("read rdata1 T+2", core_rdata_o[63:32], 32'hDEADBEEF);
      if (d == 4) chk("read rdata2 T+4", core_rdata_o[95:64], 32'hDEADBEEF);
      chk($sformatf("read mismatch T+%0d", d), mismatch_o, 3'b000);
    end

    // follower 2 write data differs in byte 0 with full byte enables
    step(mk(1'b1, 4'hF, 32'h200, 32'h12345679), 1'b1, 1'b0, 32'h0, 1'b0);
    for (int d = 1; d <= 4; d++) tick();
    core_wdata_i[95:64] = 32'h12345678;
    tick();
    chk("wr mismatch W+5", mismatch_o, 3'b100);
    chk("wr err W+5", err_o, 1'b1);
    tick();
    chk("wr mismatch W+6", mismatch_o, 3'b000);
    tick(); tick();
    chk("err sticky", err_o, 1'b1);
    step(idle_r, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("err during clear cycle", err_o, 1'b1);
    tick();
    chk("err cleared", err_o, 1'b0);

    // same byte-0 difference but byte 0 disabled
    step(mk(1'b1, 4'hE, 32'h204, 32'h12345679), 1'b1, 1'b0, 32'h0, 1'b0);
    for (int d = 1; d <= 4; d++) tick();
    core_wdata_i[95:64] = 32'h12345678;
    tick();
    chk("be masked mismatch", mismatch_o, 3'b000);
    chk("be masked err", err_o, 1'b0);

    // clear in the same cycle as a new detection
    step(mk(1'b1, 4'hF, 32'h208, 32'h12345679), 1'b1, 1'b0, 32'h0, 1'b0);
    for (int d = 1; d <= 3; d++) tick();
    step(drv_hist[sc - 4], 1'b0, 1'b0, 32'h0, 1'b1);
    core_wdata_i[95:64] = 32'h12345678;
    tick();
    chk("set beats clear err", err_o, 1'b1);
    chk("set beats clear mismatch", mismatch_o, 3'b100);
    step(idle_r, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("err cleared again", err_o, 1'b0);

    // enable dropped one cycle after a bus response
    step(mk(1'b0, 4'hF, 32'h180, 32'h0), 1'b1, 1'b0, 32'h0, 1'b0);
    step(idle_r, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
    g_en = 1'b0;
    tick();
    chk("drop locked R+1", locked_o, 1'b1);
    tick();
    chk("drop release R+2", release_o, 3'b000);
    chk("drop locked R+2", locked_o, 1'b0);
    for (int d = 2; d <= 6; d++) begin
      if (d > 2) tick();
      chk($sformatf("drop follower rvalid R+%0d", d), core_rvalid_o[2:1], 2'b00);
    end

    // re-enable, then follower 1 raises a request the leader did not make
    g_en = 1'b1;
    tick();
    chk("reenable release c0", release_o, 3'b000);
    for (int c = 1; c <= 6; c++) tick();
    chk("relocked", locked_o, 1'b1);
    tick();
    core_req_i[1] = 1'b1;
    tick();
    chk("req mismatch core1", mismatch_o, 3'b010);
    chk("req mismatch err", err_o, 1'b1);
    tick();
    chk("req mismatch pulse end", mismatch_o, 3'b000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
